// File: rtl/serializer_input_arbiter.sv
// serializer_input_arbiter
// Merges K word channels into one tagged stream for a serializer. Sources are
// served round-robin. The current owner may keep the grant for up to MaxBurst
// consecutive words while others wait. A single registered output stage holds
// {tag, payload} until the serializer acknowledges it.
module serializer_input_arbiter #(
    parameter int K        = 4,
    parameter int N        = 36,
    parameter int MaxBurst = 4,
    parameter int TagW     = $clog2(K)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [K*N-1:0]      in_d,
    input  logic [K-1:0]        in_v,
    output logic [K-1:0]        in_a,
    output logic [TagW+N-1:0]   out_d,
    output logic                out_v,
    input  logic                out_a
);

    // The burst counter must be able to hold MaxBurst itself.
    localparam int CntW = $clog2(MaxBurst + 1);
    localparam logic [CntW-1:0] MAX_BURST_C = CntW'(MaxBurst);
    localparam logic [TagW-1:0] LAST_SRC_C  = TagW'(K - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Registered state
    state_t              state_r;
    logic [TagW-1:0]     owner_r;
    logic [CntW-1:0]     burst_cnt_r;
    logic                out_v_r;
    logic [TagW+N-1:0]   out_d_r;

    // Next-state values
    state_t              state_s;
    logic [TagW-1:0]     owner_s;
    logic [CntW-1:0]     burst_cnt_s;
    logic                out_v_s;
    logic [TagW+N-1:0]   out_d_s;

    // Combinational arbitration results
    logic                load_s;
    logic                capped_s;
    logic                keep_owner_s;
    logic [TagW-1:0]     sel_s;
    logic                sel_found_s;
    logic                transfer_s;
    logic [N-1:0]        payload_s;

    // Output stage can take a new word when empty or being drained this cycle.
    always_comb begin
        load_s       = !out_v_r || out_a;
        capped_s     = (burst_cnt_r >= MAX_BURST_C);
        keep_owner_s = (state_r == BURST) && in_v[owner_r] && !capped_s;
    end

    // Source selection: continue the burst, otherwise rotate starting after
    // the owner so that the owner itself is considered last.
    always_comb begin
        int              cand;
        logic [TagW-1:0] cand_idx;
        sel_s       = '0;
        sel_found_s = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        if (load_s) begin
            if (keep_owner_s) begin
                sel_s       = owner_r;
                sel_found_s = 1'b1;
            end else begin
                for (int j = 1; j <= K; j++) begin
                    cand     = (int'(owner_r) + j) % K;
                    cand_idx = TagW'(cand);
                    if (!sel_found_s && in_v[cand_idx]) begin
                        sel_s       = cand_idx;
                        sel_found_s = 1'b1;
                    end else begin
                        sel_found_s = sel_found_s;
                    end
                end
            end
        end else begin
            sel_found_s = 1'b0;
        end
    end

    // A word moves when the output stage loads and a requester was found.
    always_comb begin
        transfer_s = load_s && sel_found_s;
        payload_s  = in_d[int'(sel_s)*N +: N];
    end

    // Acknowledge is one-hot on the winner and forced low while in reset.
    always_comb begin
        in_a = '0;
        if (reset && transfer_s) begin
            in_a[sel_s] = 1'b1;
        end else begin
            in_a = '0;
        end
    end

    // Next-state logic for the FSM, owner pointer, burst counter and output stage.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        burst_cnt_s = burst_cnt_r;
        out_v_s     = out_v_r;
        out_d_s     = out_d_r;
        if (load_s) begin
            if (sel_found_s) begin
                out_d_s = {sel_s, payload_s};
                out_v_s = 1'b1;
                state_s = BURST;
                if ((sel_s == owner_r) && (state_r == BURST) && !capped_s) begin
                    burst_cnt_s = burst_cnt_r + CntW'(1);
                end else begin
                    owner_s     = sel_s;
                    burst_cnt_s = CntW'(1);
                end
            end else begin
                // Nothing to send: go idle but keep owner as the RR pointer.
                out_v_s     = 1'b0;
                state_s     = IDLE;
                burst_cnt_s = '0;
            end
        end else begin
            // Serializer is stalling: hold everything so out_d stays stable.
            state_s = state_r;
        end
    end

    // State and output registers; reset leaves the RR pointer on the last source.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            owner_r     <= LAST_SRC_C;
            burst_cnt_r <= '0;
            out_v_r     <= 1'b0;
            out_d_r     <= '0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            burst_cnt_r <= burst_cnt_s;
            out_v_r     <= out_v_s;
            out_d_r     <= out_d_s;
        end
    end

    assign out_v = out_v_r;
    assign out_d = out_d_r;

endmodule
